// File: rtl/fll_pkg.sv
// -----------------------------------------------------------------------------
// fll_pkg
// Shared definitions for the FLL calibration sequencer:
//   - state_e     : sequencer states
//   - CORNER_*    : one-hot encodings shared by the band output and the
//                   FLL corner (code-exhaust) input
//   - RST_HOLD    : number of clk_ref cycles the FLL is held in reset
//                   between oscillator bands
//   - band_step_* : helpers that move the one-hot band one step
// -----------------------------------------------------------------------------
package fll_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RST_FLL = 3'd1,
      RUN     = 3'd2,
      LOCKED  = 3'd3,
      FAIL    = 3'd4
   } state_e;

   localparam logic [2:0] CORNER_HI  = 3'b100;
   localparam logic [2:0] CORNER_MID = 3'b010;
   localparam logic [2:0] CORNER_LO  = 3'b001;

   localparam int unsigned RST_HOLD = 2;
   localparam int unsigned HOLD_W   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   // Lock counter is sized for the largest legal LOCK_CNT (255).
   localparam int unsigned LOCK_W = 8;

   // One step toward CORNER_HI (100).
   function automatic logic [2:0] band_step_hi(input logic [2:0] band);
      return {band[1:0], 1'b0};
   endfunction

   // One step toward CORNER_LO (001).
   function automatic logic [2:0] band_step_lo(input logic [2:0] band);
      return {1'b0, band[2:1]};
   endfunction

endpackage : fll_pkg

// File: rtl/fll_cal_bounds.sv
// -----------------------------------------------------------------------------
// fll_cal_bounds
// Combinational window computation for the FLL frequency comparator.
//   lower_o = target_i - tolerance_i, clamped at 0
//   upper_o = target_i + tolerance_i, clamped at 2^N-1
// Ports:
//   target_i    in  N  expected count per gate
//   tolerance_i in  N  allowed +/- count error
//   lower_o     out N  saturated lower window
//   upper_o     out N  saturated upper window
// -----------------------------------------------------------------------------
module fll_cal_bounds #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] target_i,
   input  logic [N-1:0] tolerance_i,
   output logic [N-1:0] lower_o,
   output logic [N-1:0] upper_o
);

   // One extra bit catches the carry out of the addition.
   logic [N:0] sum;

   assign sum = {1'b0, target_i} + {1'b0, tolerance_i};

   always_comb begin
      lower_o = (target_i >= tolerance_i) ? (target_i - tolerance_i) : '0;
      upper_o = sum[N] ? '1 : sum[N-1:0];
   end

endmodule : fll_cal_bounds

// File: rtl/fll_cal_seq.sv
// -----------------------------------------------------------------------------
// fll_cal_seq
// Calibration sequencer for a frequency-locked loop. On start it programs the
// FLL count window and gate length, resets the FLL, then watches the FLL gate
// strobes: consecutive in-window strobes declare lock, code-exhaust corners
// walk the oscillator band one step, and a strobe budget bounds the search.
//
// Ports:
//   clk_ref      in   1     reference clock, rising edge
//   reset_n      in   1     asynchronous active-low reset
//   start        in   1     pulse; begin (or restart from FAIL) calibration
//   abort        in   1     pulse; back to IDLE from anywhere, wins over start
//   target       in   N     expected clk_in count per gate
//   tolerance    in   N     allowed +/- count error
//   gate_cfg     in   N     gate length in clk_ref cycles
//   max_strobes  in   TO_W  strobes allowed per band, 0 = no timeout
//   fll_strobe   in   1     FLL gate-complete pulse
//   fll_locked   in   1     FLL in-window flag, valid with fll_strobe
//   fll_corner   in   3     FLL code exhaust: 100 high, 001 low, 010 none
//   fll_reset    out  1     active-high FLL reset
//   lower_bound  out  N     FLL lower window
//   upper_bound  out  N     FLL upper window
//   gate_time    out  N     FLL gate length
//   band         out  3     one-hot oscillator band
//   busy         out  1     high in RST_FLL and RUN
//   done         out  1     high in LOCKED
//   fail         out  1     high in FAIL
//   lock_lost    out  1     one-cycle pulse when lock drops in LOCKED
//
// Build option:
//   FLL_CAL_RELOCK_EN  when defined, a lock loss re-enters RST_FLL on the
//                      current band instead of failing.
// -----------------------------------------------------------------------------
module fll_cal_seq
   import fll_pkg::*;
#(
   parameter int unsigned N        = 32,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned TO_W     = 16
) (
   input  logic            clk_ref,
   input  logic            reset_n,
   input  logic            start,
   input  logic            abort,
   input  logic [N-1:0]    target,
   input  logic [N-1:0]    tolerance,
   input  logic [N-1:0]    gate_cfg,
   input  logic [TO_W-1:0] max_strobes,
   input  logic            fll_strobe,
   input  logic            fll_locked,
   input  logic [2:0]      fll_corner,
   output logic            fll_reset,
   output logic [N-1:0]    lower_bound,
   output logic [N-1:0]    upper_bound,
   output logic [N-1:0]    gate_time,
   output logic [2:0]      band,
   output logic            busy,
   output logic            done,
   output logic            fail,
   output logic            lock_lost
);

   state_e state_q, state_d;

   logic [2:0]        band_q, band_d;
   logic [N-1:0]      lower_q, lower_d;
   logic [N-1:0]      upper_q, upper_d;
   logic [N-1:0]      gate_q, gate_d;
   logic [TO_W-1:0]   max_q, max_d;
   logic [TO_W-1:0]   strobe_cnt_q, strobe_cnt_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              lock_lost_q, lock_lost_d;

   logic [N-1:0]      lower_calc, upper_calc;

   // Values the counters take if the current RUN strobe is counted.
   logic [TO_W-1:0]   strobe_cnt_inc;
   logic [LOCK_W-1:0] lock_cnt_inc;
   logic              corner_hi, corner_lo;
   logic              hold_done, lock_hit, timeout_hit, start_taken;

   fll_cal_bounds #(
      .N (N)
   ) u_bounds (
      .target_i    (target),
      .tolerance_i (tolerance),
      .lower_o     (lower_calc),
      .upper_o     (upper_calc)
   );

   assign strobe_cnt_inc = strobe_cnt_q + 1'b1;
   assign lock_cnt_inc   = fll_locked ? (lock_cnt_q + 1'b1) : '0;
   assign corner_hi      = (fll_corner == CORNER_HI);
   assign corner_lo      = (fll_corner == CORNER_LO);
   assign hold_done      = (hold_cnt_q == HOLD_W'(RST_HOLD - 1));
   assign lock_hit       = (lock_cnt_inc == LOCK_W'(LOCK_CNT));
   assign timeout_hit    = (max_q != '0) && (strobe_cnt_inc == max_q);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge clk_ref or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) state_d = RST_FLL;
            end
            RST_FLL: begin
               if (hold_done) state_d = RUN;
            end
            RUN: begin
               if (fll_strobe) begin
                  // Corners outrank lock counting on the same strobe.
                  if (corner_hi) begin
                     state_d = (band_q == CORNER_HI) ? FAIL : RST_FLL;
                  end else if (corner_lo) begin
                     state_d = (band_q == CORNER_LO) ? FAIL : RST_FLL;
                  end else if (lock_hit) begin
                     state_d = LOCKED;
                  end else if (timeout_hit) begin
                     state_d = FAIL;
                  end
               end
            end
            LOCKED: begin
               if (fll_strobe && !fll_locked) begin
`ifdef FLL_CAL_RELOCK_EN
                  state_d = RST_FLL;
`else
                  state_d = FAIL;
`endif
               end
            end
            FAIL: begin
               if (start) state_d = RST_FLL;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath next values
   // ---------------------------------------------------------------------------
   // A (re)start is the only way into RST_FLL from IDLE or FAIL.
   assign start_taken = (state_d == RST_FLL) && ((state_q == IDLE) || (state_q == FAIL));

   always_comb begin
      band_d       = band_q;
      lower_d      = lower_q;
      upper_d      = upper_q;
      gate_d       = gate_q;
      max_d        = max_q;
      strobe_cnt_d = strobe_cnt_q;
      lock_cnt_d   = lock_cnt_q;
      hold_cnt_d   = '0;
      lock_lost_d  = (state_q == LOCKED) && ((state_d == FAIL) || (state_d == RST_FLL));

      if (start_taken) begin
         band_d  = CORNER_MID;
         lower_d = lower_calc;
         upper_d = upper_calc;
         gate_d  = gate_cfg;
         max_d   = max_strobes;
      end else if ((state_q == RUN) && (state_d == RST_FLL)) begin
         // Leaving RUN for RST_FLL only happens on a corner with room to move.
         band_d = corner_hi ? band_step_hi(band_q) : band_step_lo(band_q);
      end

      if (state_q == RST_FLL) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
      end

      if (state_q != RUN) begin
         // Every band starts with fresh strobe and lock counts.
         strobe_cnt_d = '0;
         lock_cnt_d   = '0;
      end else if (fll_strobe) begin
         strobe_cnt_d = strobe_cnt_inc;
         lock_cnt_d   = lock_cnt_inc;
      end
   end

   always_ff @(posedge clk_ref or negedge reset_n) begin
      if (!reset_n) begin
         band_q       <= CORNER_MID;
         lower_q      <= '0;
         upper_q      <= '0;
         gate_q       <= '0;
         max_q        <= '0;
         strobe_cnt_q <= '0;
         lock_cnt_q   <= '0;
         hold_cnt_q   <= '0;
         lock_lost_q  <= 1'b0;
      end else begin
         band_q       <= band_d;
         lower_q      <= lower_d;
         upper_q      <= upper_d;
         gate_q       <= gate_d;
         max_q        <= max_d;
         strobe_cnt_q <= strobe_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         lock_lost_q  <= lock_lost_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs decoded from state
   // ---------------------------------------------------------------------------
   always_comb begin
      fll_reset = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      fail      = 1'b0;
      unique case (state_q)
         IDLE:    fll_reset = 1'b1;
         RST_FLL: busy      = 1'b1;
         RUN: begin
            fll_reset = 1'b0;
            busy      = 1'b1;
         end
         LOCKED: begin
            fll_reset = 1'b0;
            done      = 1'b1;
         end
         FAIL:    fail      = 1'b1;
         default: fll_reset = 1'b1;
      endcase
   end

   assign lower_bound = lower_q;
   assign upper_bound = upper_q;
   assign gate_time   = gate_q;
   assign band        = band_q;
   assign lock_lost   = lock_lost_q;

endmodule : fll_cal_seq

// File: tb/tb_fll_cal_seq.sv
// -----------------------------------------------------------------------------
// tb_fll_cal_seq
// Self-checking bench for fll_cal_seq. Directed scenarios cover reset, lock,
// bound saturation, band walking, timeout, lock loss and abort; a randomized
// scenario runs strobe sequences against an integer-band reference model.
// Honours FLL_CAL_RELOCK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fll_cal_seq;
   import fll_pkg::*;

   localparam int N    = 32;
   localparam int TO_W = 16;

   logic            clk_ref = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [N-1:0]    target = '0;
   logic [N-1:0]    tolerance = '0;
   logic [N-1:0]    gate_cfg = '0;
   logic [TO_W-1:0] max_strobes = '0;
   logic            fll_strobe = 1'b0;
   logic            fll_locked = 1'b0;
   logic [2:0]      fll_corner = CORNER_MID;
   logic            fll_reset;
   logic [N-1:0]    lower_bound, upper_bound, gate_time;
   logic [2:0]      band;
   logic            busy, done, fail, lock_lost;

   int vectors = 0;
   int miscompares = 0;

   fll_cal_seq #(
      .N        (N),
      .LOCK_CNT (4),
      .TO_W     (TO_W)
   ) dut (
      .clk_ref     (clk_ref),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .target      (target),
      .tolerance   (tolerance),
      .gate_cfg    (gate_cfg),
      .max_strobes (max_strobes),
      .fll_strobe  (fll_strobe),
      .fll_locked  (fll_locked),
      .fll_corner  (fll_corner),
      .fll_reset   (fll_reset),
      .lower_bound (lower_bound),
      .upper_bound (upper_bound),
      .gate_time   (gate_time),
      .band        (band),
      .busy        (busy),
      .done        (done),
      .fail        (fail),
      .lock_lost   (lock_lost)
   );

   always #5 clk_ref = ~clk_ref;

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_ref);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      fll_strobe = 1'b0;
      fll_locked = 1'b0;
      fll_corner = CORNER_MID;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic do_start(input logic [N-1:0] t, input logic [N-1:0] tol,
                           input logic [N-1:0] g, input logic [TO_W-1:0] m);
      target = t;
      tolerance = tol;
      gate_cfg = g;
      max_strobes = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic do_strobe(input logic locked, input logic [2:0] corner);
      fll_strobe = 1'b1;
      fll_locked = locked;
      fll_corner = corner;
      tick();
      fll_strobe = 1'b0;
      fll_locked = 1'b0;
      fll_corner = CORNER_MID;
   endtask

   // Counts consecutive samples with fll_reset high, stopping when it drops.
   task automatic wait_run(output int rst_cycles);
      rst_cycles = 0;
      for (int i = 0; i < 8 && fll_reset === 1'b1; i++) begin
         rst_cycles++;
         tick();
      end
      if (fll_reset !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_run_timeout: fll_reset still %b after %0d cycles, required 0", fll_reset, rst_cycles);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      vectors++;
      if ({fll_reset, busy, done, fail, lock_lost} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b required 10000", {fll_reset, busy, done, fail, lock_lost});
      end
      vectors++;
      if (band !== CORNER_MID) begin
         miscompares++;
         $display("FAIL reset_band: got %b required 010", band);
      end
      vectors++;
      if ({lower_bound, upper_bound, gate_time} !== 96'h0) begin
         miscompares++;
         $display("FAIL reset_bounds: got %0h/%0h/%0h required 0/0/0", lower_bound, upper_bound, gate_time);
      end
   endtask

   task automatic test_basic_lock();
      int rc;
      do_start(32'd1000, 32'd10, 32'd100, '0);
      vectors++;
      if ({lower_bound, upper_bound, gate_time} !== {32'd990, 32'd1010, 32'd100}) begin
         miscompares++;
         $display("FAIL lock_bounds: got %0d/%0d/%0d required 990/1010/100", lower_bound, upper_bound, gate_time);
      end
      vectors++;
      if ({busy, band} !== {1'b1, CORNER_MID}) begin
         miscompares++;
         $display("FAIL lock_busy_band: got %b required 1010", {busy, band});
      end
      wait_run(rc);
      vectors++;
      if (rc !== 2) begin
         miscompares++;
         $display("FAIL lock_rst_len: got %0d required 2", rc);
      end
      for (int i = 0; i < 3; i++) do_strobe(1'b1, CORNER_MID);
      vectors++;
      if ({done, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL lock_after3: got done/busy %b required 01", {done, busy});
      end
      do_strobe(1'b1, CORNER_MID);
      vectors++;
      if ({done, fail, busy, band} !== {3'b100, CORNER_MID}) begin
         miscompares++;
         $display("FAIL lock_after4: got %b required 100010", {done, fail, busy, band});
      end
   endtask

   task automatic test_saturation();
      int rc;
      do_abort();
      do_start(32'd5, 32'd10, 32'd7, '0);
      vectors++;
      if ({lower_bound, upper_bound} !== {32'd0, 32'd15}) begin
         miscompares++;
         $display("FAIL sat_low: got %0d/%0d required 0/15", lower_bound, upper_bound);
      end
      wait_run(rc);
      // A start while running is ignored and keeps the latched window.
      do_start(32'd500, 32'd1, 32'd9, '0);
      vectors++;
      if ({lower_bound, upper_bound, gate_time, busy, fll_reset} !== {32'd0, 32'd15, 32'd7, 2'b10}) begin
         miscompares++;
         $display("FAIL start_ignored: got %0d/%0d/%0d busy=%b rst=%b required 0/15/7 busy=1 rst=0",
                  lower_bound, upper_bound, gate_time, busy, fll_reset);
      end
      do_abort();
      do_start(32'hFFFF_FFFD, 32'd10, 32'd7, '0);
      vectors++;
      if ({lower_bound, upper_bound} !== {32'hFFFF_FFF3, 32'hFFFF_FFFF}) begin
         miscompares++;
         $display("FAIL sat_high: got %0h/%0h required fffffff3/ffffffff", lower_bound, upper_bound);
      end
      wait_run(rc);
   endtask

   task automatic test_corner();
      int rc;
      do_abort();
      do_start(32'd1000, 32'd10, 32'd100, '0);
      wait_run(rc);
      do_strobe(1'b1, CORNER_HI);
      vectors++;
      if (band !== CORNER_HI) begin
         miscompares++;
         $display("FAIL corner_hi_step: got %b required 100", band);
      end
      wait_run(rc);
      vectors++;
      if (rc !== 2) begin
         miscompares++;
         $display("FAIL corner_rst_len: got %0d required 2", rc);
      end
      do_strobe(1'b0, CORNER_HI);
      vectors++;
      if ({fail, busy, fll_reset, band} !== {3'b101, CORNER_HI}) begin
         miscompares++;
         $display("FAIL corner_hi_fail: got %b required 101100", {fail, busy, fll_reset, band});
      end
      // Restart straight out of FAIL, then walk down to the low corner.
      do_start(32'd1000, 32'd10, 32'd100, '0);
      vectors++;
      if ({fail, busy, band} !== {2'b01, CORNER_MID}) begin
         miscompares++;
         $display("FAIL restart: got %b required 01010", {fail, busy, band});
      end
      wait_run(rc);
      do_strobe(1'b0, CORNER_LO);
      wait_run(rc);
      do_strobe(1'b1, CORNER_LO);
      vectors++;
      if ({fail, band} !== {1'b1, CORNER_LO}) begin
         miscompares++;
         $display("FAIL corner_lo_fail: got %b required 1001", {fail, band});
      end
   endtask

   task automatic test_timeout();
      int rc;
      do_abort();
      do_start(32'd1000, 32'd10, 32'd100, 16'd3);
      wait_run(rc);
      do_strobe(1'b0, CORNER_MID);
      do_strobe(1'b0, CORNER_MID);
      vectors++;
      if ({fail, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL timeout_early: got fail/busy %b required 01", {fail, busy});
      end
      do_strobe(1'b0, CORNER_MID);
      vectors++;
      if ({fail, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL timeout_hit: got fail/busy %b required 10", {fail, busy});
      end
   endtask

   task automatic test_lock_lost();
      int rc;
      do_abort();
      do_start(32'd1000, 32'd10, 32'd100, '0);
      wait_run(rc);
      for (int i = 0; i < 4; i++) do_strobe(1'b1, CORNER_MID);
      do_strobe(1'b0, CORNER_MID);
`ifdef FLL_CAL_RELOCK_EN
      vectors++;
      if ({lock_lost, done, fail, busy, fll_reset} !== 5'b10011) begin
         miscompares++;
         $display("FAIL lost_relock: got %b required 10011", {lock_lost, done, fail, busy, fll_reset});
      end
`else
      vectors++;
      if ({lock_lost, done, fail, busy} !== 4'b1010) begin
         miscompares++;
         $display("FAIL lost_fail: got %b required 1010", {lock_lost, done, fail, busy});
      end
`endif
      tick();
      vectors++;
      if (lock_lost !== 1'b0) begin
         miscompares++;
         $display("FAIL lost_pulse_len: got %b required 0", lock_lost);
      end
   endtask

   task automatic test_abort();
      int rc;
      do_abort();
      do_start(32'd1000, 32'd10, 32'd100, '0);
      wait_run(rc);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      vectors++;
      if ({busy, done, fail, fll_reset} !== 4'b0001) begin
         miscompares++;
         $display("FAIL abort_start: got %b required 0001", {busy, done, fail, fll_reset});
      end
      // Abort from LOCKED clears done.
      do_start(32'd1000, 32'd10, 32'd100, '0);
      wait_run(rc);
      for (int i = 0; i < 4; i++) do_strobe(1'b1, CORNER_MID);
      do_abort();
      vectors++;
      if ({busy, done, fail} !== 3'b000) begin
         miscompares++;
         $display("FAIL abort_locked: got %b required 000", {busy, done, fail});
      end
      // Asynchronous reset mid-RUN, checked before the next clock edge.
      do_start(32'd1234, 32'd4, 32'd55, 16'd9);
      wait_run(rc);
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({fll_reset, busy, done, fail, lock_lost, band} !== {5'b10000, CORNER_MID}) begin
         miscompares++;
         $display("FAIL async_reset_flags: got %b required 10000010", {fll_reset, busy, done, fail, lock_lost, band});
      end
      vectors++;
      if ({lower_bound, upper_bound, gate_time} !== 96'h0) begin
         miscompares++;
         $display("FAIL async_reset_bounds: got %0h/%0h/%0h required 0/0/0", lower_bound, upper_bound, gate_time);
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Reference model: band is an integer 0 (low) .. 2 (high); the run is
   // described by a few flags and counts advanced once per strobe.
   task automatic test_random();
      int rc;
      for (int it = 0; it < 40; it++) begin
         logic [N-1:0]    t, tol;
         logic [TO_W-1:0] m;
         longint unsigned lo_exp, hi_exp;
         int b, strobes, locks;
         bit is_locked, is_failed, restart, exp_lost, lk;
         logic [2:0] corner;
         int sel, r;

         sel = $urandom_range(0, 2);
         tol = N'($urandom_range(0, 2000));
         if (sel == 0)      t = N'($urandom_range(0, 1500));
         else if (sel == 1) t = 32'hFFFF_FFFF - N'($urandom_range(0, 1500));
         else               t = $urandom;
         m = TO_W'($urandom_range(0, 6));

         lo_exp = (longint'(t) >= longint'(tol)) ? longint'(t) - longint'(tol) : 0;
         hi_exp = longint'(t) + longint'(tol);
         if (hi_exp > 64'hFFFF_FFFF) hi_exp = 64'hFFFF_FFFF;

         do_abort();
         vectors++;
         if ({busy, done, fail, fll_reset} !== 4'b0001) begin
            miscompares++;
            $display("FAIL rnd_abort it=%0d: got %b required 0001", it, {busy, done, fail, fll_reset});
         end
         do_start(t, tol, 32'd64, m);
         vectors++;
         if ({lower_bound, upper_bound} !== {lo_exp[31:0], hi_exp[31:0]}) begin
            miscompares++;
            $display("FAIL rnd_bounds it=%0d: got %0h/%0h required %0h/%0h", it,
                     lower_bound, upper_bound, lo_exp[31:0], hi_exp[31:0]);
         end
         wait_run(rc);

         b = 1;
         strobes = 0;
         locks = 0;
         is_locked = 0;
         is_failed = 0;
         for (int k = 0; k < 16 && !is_failed; k++) begin
            lk = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            corner = (r == 0) ? CORNER_HI : (r == 1) ? CORNER_LO : CORNER_MID;
            restart = 0;
            exp_lost = 0;
            if (!is_locked) begin
               if (corner == CORNER_HI) begin
                  if (b == 2) is_failed = 1;
                  else begin b++; restart = 1; end
               end else if (corner == CORNER_LO) begin
                  if (b == 0) is_failed = 1;
                  else begin b--; restart = 1; end
               end else begin
                  strobes++;
                  locks = lk ? locks + 1 : 0;
                  if (locks == 4) is_locked = 1;
                  else if (m != 0 && strobes == int'(m)) is_failed = 1;
               end
            end else if (!lk) begin
               exp_lost = 1;
               is_locked = 0;
`ifdef FLL_CAL_RELOCK_EN
               restart = 1;
`else
               is_failed = 1;
`endif
            end
            if (restart) begin
               strobes = 0;
               locks = 0;
            end

            do_strobe(lk, corner);
            vectors++;
            if (lock_lost !== exp_lost) begin
               miscompares++;
               $display("FAIL rnd_lost it=%0d k=%0d: got %b required %b", it, k, lock_lost, exp_lost);
            end
            if (restart) begin
               wait_run(rc);
               vectors++;
               if (rc !== 2) begin
                  miscompares++;
                  $display("FAIL rnd_rst_len it=%0d k=%0d: got %0d required 2", it, k, rc);
               end
            end
            vectors++;
            if ({busy, done, fail, band} !== {!is_failed && !is_locked, is_locked, is_failed, 3'(3'b001 << b)}) begin
               miscompares++;
               $display("FAIL rnd_state it=%0d k=%0d: got %b required %b", it, k, {busy, done, fail, band},
                        {!is_failed && !is_locked, is_locked, is_failed, 3'(3'b001 << b)});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_lock();
      test_saturation();
      test_corner();
      test_timeout();
      test_lock_lost();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_fll_cal_seq

// File: doc/fll_cal_seq.md
FLL_CAL_SEQ -- requirements
Module: fll_cal_seq

Interface
REQ-001 Parameter: N, 32, width of FLL count, code and bound buses.
REQ-002 Parameter: LOCK_CNT, 4, consecutive locked strobes required to declare lock (1..255).
REQ-003 Parameter: TO_W, 16, width of strobe timeout counter.
REQ-004 The ports SHALL be, one per line:
- clk_ref  in  1  reference clock; all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins calibration
- abort  in  1  one-cycle pulse; returns to IDLE
- target  in  N  expected clk_in count per gate
- tolerance  in  N  allowed +/- count error
- gate_cfg  in  N  gate length in clk_ref cycles
- max_strobes  in  TO_W  strobes allowed per band before fail
- fll_strobe  in  1  FLL gate-complete pulse
- fll_locked  in  1  FLL in-window flag
- fll_corner  in  3  FLL code-exhaust flag; 100 = high end, 001 = low end, 010 = none
- fll_reset  out  1  active-high reset to FLL
- lower_bound  out  N  FLL lower window
- upper_bound  out  N  FLL upper window
- gate_time  out  N  FLL gate length
- band  out  3  oscillator band, one-hot; 100, 010 or 001
- busy  out  1  calibration in progress
- done  out  1  level; lock achieved
- fail  out  1  level; calibration failed
- lock_lost  out  1  one-cycle pulse when lock drops in LOCKED

Function
REQ-005 States SHALL be IDLE, RST_FLL, RUN, LOCKED, FAIL.
REQ-006 IDLE: fll_reset=1; on start, latch target/tolerance/gate_cfg/max_strobes, set band=010, go to RST_FLL.
REQ-007 Bounds SHALL be registered at start: lower_bound = target-tolerance, saturating at 0; upper_bound = target+tolerance, saturating at 2^N-1; gate_time = gate_cfg.
REQ-008 RST_FLL SHALL hold fll_reset=1 for exactly 2 cycles, clear strobe and lock counters, then enter RUN.
REQ-009 RUN: fll_reset=0; each fll_strobe increments the strobe counter; fll_locked=1 at a strobe increments the lock counter, fll_locked=0 clears it.
REQ-010 RUN: lock counter reaching LOCK_CNT SHALL enter LOCKED with done=1 on the next cycle.
REQ-011 RUN: fll_corner=100 at a strobe SHALL shift band one step toward 100 and enter RST_FLL; at band=100 it SHALL enter FAIL instead.
REQ-012 RUN: fll_corner=001 at a strobe SHALL shift band one step toward 001 and enter RST_FLL; at band=001 it SHALL enter FAIL instead.
REQ-013 Corner evaluation SHALL take priority over lock counting at the same strobe.
REQ-014 RUN: strobe counter reaching max_strobes without lock SHALL enter FAIL; max_strobes=0 disables the timeout.
REQ-015 LOCKED: fll_locked=0 at a strobe SHALL pulse lock_lost, clear done, and enter FAIL (default build).
REQ-016 FAIL: fail=1, fll_reset=1, band held; only start (restart) or abort leaves it.
REQ-017 abort SHALL return to IDLE from any state in one cycle, clearing done and fail; abort wins over a simultaneous start.
REQ-018 start outside IDLE/FAIL SHALL be ignored.
REQ-019 busy SHALL be 1 exactly in RST_FLL and RUN.

Reset
REQ-020 reset_n low SHALL asynchronously force IDLE, fll_reset=1, band=010, bounds and gate_time 0, busy/done/fail/lock_lost 0, all counters 0.
REQ-021 Reset mid-calibration SHALL discard all latched configuration.

Configuration
REQ-022 Macro FLL_CAL_RELOCK_EN: when defined, lock loss in LOCKED pulses lock_lost, clears done and enters RST_FLL with the current band and fresh counters instead of FAIL; when undefined, REQ-015 applies.

Structure
REQ-023 Package fll_pkg SHALL hold the state enum, the band/corner encodings (CORNER_HI=100, CORNER_MID=010, CORNER_LO=001) and the RST_FLL hold length (2).
REQ-024 A sub-module fll_cal_bounds SHALL compute the saturating bounds; all else stays in fll_cal_seq.

Verification
REQ-025 N=32, target=1000, tolerance=10, gate_cfg=100, locked=1 on 4 strobes -> bounds 990/1010, done=1 after 4th strobe, band=010.
REQ-026 target=5, tolerance=10 -> lower_bound=0; target=2^32-3, tolerance=10 -> upper_bound=2^32-1.
REQ-027 fll_corner=100 at strobe with band=010 -> band=100, fll_reset high exactly 2 cycles; repeat -> fail=1.
REQ-028 max_strobes=3, locked never -> fail=1 after 3rd strobe, busy=0.
REQ-029 In LOCKED, fll_locked=0 at strobe -> lock_lost pulse 1 cycle; fail=1 without macro, RST_FLL with FLL_CAL_RELOCK_EN.
REQ-030 abort and start in same cycle during RUN -> IDLE, done=0, fail=0; reset_n low mid-RUN -> all outputs at reset values immediately.
